// File: rtl/wb_spi_top_level_if.sv
// Wishbone classic slave-side bundle for the SPI bridge.
// Signal names match the bus pins of the bridge.
interface wb_spi_top_level_if;
    logic [31:0] wb_addr;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic [31:0] wb_dout;
    logic [31:0] wb_din;
    logic        wb_ack;

    modport master (
        output wb_addr, wb_we, wb_stb, wb_cyc, wb_dout,
        input  wb_din, wb_ack
    );

    modport slave (
        input  wb_addr, wb_we, wb_stb, wb_cyc, wb_dout,
        output wb_din, wb_ack
    );
endinterface

// File: rtl/wb_spi_top_level.sv
// Wishbone-slave SPI master: 16-deep command FIFO, mode-0 byte engine,
// programmable SCK divider and receive-ready interrupt.
module wb_spi_top_level (
    input  logic              clk,
    input  logic              rst,
    wb_spi_top_level_if.slave wb,
    output logic              spi_mosi,
    output logic              spi_sck,
    output logic              spi_ss,
    input  logic              spi_miso,
    output logic              spi_dint
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DESEL} state_t;

    state_t      st;
    logic [10:0] mem [16];
    logic [3:0]  wptr, rptr;
    logic [4:0]  cnt;
    logic [10:0] word, head;
    logic [15:0] div, div_cur, tmr;
    logic [3:0]  half;
    logic [7:0]  tx_sh, rx_sh, rx;
    logic [7:0]  reg_a;
    logic        done, req, full, busy, pop, push, stall, go;
    logic        rd_clear, half_end;
    logic        unused;

    assign unused   = ^{wb.wb_addr[31:8], wb.wb_dout[31:16]};
    assign req      = wb.wb_stb & wb.wb_cyc;
    assign reg_a    = wb.wb_addr[7:0];
    assign full     = cnt[4];
    assign head     = mem[rptr];
    assign busy     = (st != IDLE) || (cnt != 5'd0);
    assign pop      = (st == IDLE) && (cnt != 5'd0);
    // A full FIFO may still accept a push in the cycle the engine pops.
    assign stall    = wb.wb_we && (reg_a == 8'h10) && full && !pop;
    assign go       = req && !done && !stall;
    assign push     = go && wb.wb_we && (reg_a == 8'h10);
    assign rd_clear = go && !wb.wb_we && (reg_a == 8'h10);
    assign half_end = (tmr == div_cur);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wb.wb_dout[10:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 4'd1;
            if (pop)  rptr <= rptr + 4'd1;
            cnt <= cnt + 5'(push) - 5'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.wb_ack <= 1'b0;
            wb.wb_din <= '0;
            done      <= 1'b0;
            div       <= 16'h00ff;
        end else begin
            wb.wb_ack <= 1'b0;
            if (!req) begin
                done <= 1'b0;
            end else if (go) begin
                done      <= 1'b1;
                wb.wb_ack <= 1'b1;
                if (wb.wb_we) begin
                    if (reg_a == 8'h20) div <= wb.wb_dout[15:0];
                end else begin
                    unique case (reg_a)
                        8'h10:   wb.wb_din <= {24'h0, rx};
                        8'h18:   wb.wb_din <= {29'h0, full, spi_dint, busy};
                        8'h20:   wb.wb_din <= {16'h0, div};
                        default: wb.wb_din <= '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            spi_ss   <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_dint <= 1'b0;
            rx       <= '0;
            word     <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            tmr      <= '0;
            half     <= '0;
            div_cur  <= 16'h00ff;
        end else begin
            tmr <= half_end ? 16'd0 : tmr + 16'd1;
            if (rd_clear) spi_dint <= 1'b0;
            case (st)
                IDLE: begin
                    tmr <= '0;
                    if (pop) begin
                        word     <= head;
                        tx_sh    <= head[7:0];
                        spi_mosi <= head[7];
                        div_cur  <= div;
                        if (head[8]) spi_ss <= 1'b0;
                        st <= SETUP;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        spi_sck <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], spi_miso};
                        half    <= '0;
                        st      <= SHIFT;
                    end
                end
                // Even halves end on a falling edge, odd ones on a rising edge.
                SHIFT: begin
                    if (half_end) begin
                        half <= half + 4'd1;
                        if (!half[0]) begin
                            spi_sck  <= 1'b0;
                            spi_mosi <= (half == 4'd14) ? 1'b0 : tx_sh[6];
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                        end else if (half == 4'd15) begin
                            st <= HOLD;
                            if (word[10]) begin
                                rx       <= rx_sh;
                                spi_dint <= 1'b1;
                            end
                        end else begin
                            spi_sck <= 1'b1;
                            rx_sh   <= {rx_sh[6:0], spi_miso};
                        end
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        if (word[9]) begin
                            spi_ss <= 1'b1;
                            half   <= '0;
                            st     <= DESEL;
                        end else begin
                            st <= IDLE;
                        end
                    end
                end
                DESEL: begin
                    if (half_end) begin
                        half <= half + 4'd1;
                        if (half[0]) st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_spi_top_level.sv
// Bench for the Wishbone SPI bridge: a byte-level SPI device model and
// randomized frames checked against the expected byte stream.
module tb_wb_spi_top_level;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_mosi, spi_sck, spi_ss, spi_dint;
    logic spi_miso = 1'b0;

    wb_spi_top_level_if bus();

    wb_spi_top_level dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (bus),
        .spi_mosi (spi_mosi),
        .spi_sck  (spi_sck),
        .spi_ss   (spi_ss),
        .spi_miso (spi_miso),
        .spi_dint (spi_dint)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] resp_q[$];
    logic [7:0] got_q[$];
    int         win_q[$];
    int         pulses = 0;
    int         dev_bit = 0;
    int         hp = 0;
    logic [7:0] dev_tx = 8'h00;
    logic [7:0] dev_rx = 8'h00;
    time        t_rise = 0;
    logic [7:0] rx_exp = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] next_resp();
        if (resp_q.size() == 0) return 8'h00;
        return resp_q.pop_front();
    endfunction

    // SPI device: mode 0, MSB first, one response byte per transferred byte
    always @(negedge spi_ss) begin
        pulses   = 0;
        dev_bit  = 0;
        dev_tx   = next_resp();
        spi_miso = dev_tx[7];
    end

    always @(posedge spi_ss) win_q.push_back(pulses);

    always @(posedge spi_sck) begin
        if (!spi_ss) begin
            dev_rx = {dev_rx[6:0], spi_mosi};
            pulses++;
            dev_bit++;
            t_rise = $time;
            if (dev_bit == 8) begin
                got_q.push_back(dev_rx);
                dev_bit = 0;
            end
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_ss) begin
            hp = int'(($time - t_rise) / 10);
            if (dev_bit == 0) dev_tx = next_resp();
            else dev_tx = dev_tx << 1;
            spi_miso = dev_tx[7];
        end
    end

    task automatic clear_dev();
        resp_q.delete();
        got_q.delete();
        win_q.delete();
    endtask

    task automatic wb_xfer(input logic [7:0] a, input logic we,
                           input logic [31:0] d, output logic [31:0] q,
                           output int cyc);
        @(negedge clk);
        bus.wb_addr = {24'h0, a};
        bus.wb_we   = we;
        bus.wb_dout = d;
        bus.wb_stb  = 1'b1;
        bus.wb_cyc  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.wb_ack && cyc < 400);
        if (!bus.wb_ack) chk("ack_timeout", {31'h0, bus.wb_ack}, 32'h1);
        q = bus.wb_din;
        bus.wb_stb = 1'b0;
        bus.wb_cyc = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] q;
        int c;
        wb_xfer(a, 1'b1, d, q, c);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] q);
        int c;
        wb_xfer(a, 1'b0, 32'h0, q, c);
    endtask

    task automatic wait_idle(input int maxc);
        logic [31:0] s;
        int n = 0;
        do begin
            rd(8'h18, s);
            n += 2;
        end while (s[0] && n < maxc);
        chk("idle", {31'h0, s[0]}, 32'h0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp[$],
                               input int exp_pulses);
        chk({tag, "_nbytes"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            chk({tag, "_byte"}, {24'h0, got_q[i]}, {24'h0, exp[i]});
        chk({tag, "_windows"}, win_q.size(), 1);
        if (win_q.size() > 0) chk({tag, "_pulses"}, win_q[0], exp_pulses);
        chk({tag, "_ss_idle"}, {31'h0, spi_ss}, 32'h1);
        chk({tag, "_sck_idle"}, {31'h0, spi_sck}, 32'h0);
        chk({tag, "_mosi_idle"}, {31'h0, spi_mosi}, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ss"}, {31'h0, spi_ss}, 32'h1);
        chk({tag, "_sck"}, {31'h0, spi_sck}, 32'h0);
        chk({tag, "_mosi"}, {31'h0, spi_mosi}, 32'h0);
        chk({tag, "_dint"}, {31'h0, spi_dint}, 32'h0);
        chk({tag, "_ack"}, {31'h0, bus.wb_ack}, 32'h0);
        chk({tag, "_din"}, bus.wb_din, 32'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        logic [7:0]  exp[$];
        int          c, acks, n, t;
        logic        dint_exp;
        logic [7:0]  b, r;
        logic        rcv;

        bus.wb_addr = '0;
        bus.wb_we   = 1'b0;
        bus.wb_dout = '0;
        bus.wb_stb  = 1'b0;
        bus.wb_cyc  = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b0;
        rd(8'h18, q); chk("rst0_status", q, 32'h0);
        rd(8'h20, q); chk("rst0_div", q, 32'h00ff);
        rd(8'h44, q); chk("unmapped", q, 32'h0);

        // single-byte WREN frame at a slow divider
        wr(8'h20, 32'h0203);
        rd(8'h20, q); chk("div_rb", q, 32'h0203);
        clear_dev();
        wr(8'h10, 32'h306);
        wait_idle(60000);
        exp = '{8'h06};
        check_frame("wren", exp, 8);
        chk("wren_halfper", hp, 516);
        chk("wren_dint", {31'h0, spi_dint}, 32'h0);

        // three-byte frame, writes acked without waiting on SPI
        clear_dev();
        wb_xfer(8'h10, 1'b1, 32'h102, q, c); chk("ack_lat0", c, 1);
        wb_xfer(8'h10, 1'b1, 32'h0fe, q, c); chk("ack_lat1", c, 1);
        wb_xfer(8'h10, 1'b1, 32'h2d3, q, c); chk("ack_lat2", c, 1);
        wait_idle(80000);
        exp = '{8'h02, 8'hfe, 8'hd3};
        check_frame("frame3", exp, 24);

        // read a byte back from the device
        wr(8'h20, 32'h3);
        clear_dev();
        resp_q = '{8'hff, 8'hff, 8'hd3};
        wr(8'h10, 32'h103);
        wr(8'h10, 32'h0fe);
        wr(8'h10, 32'h600);
        t = 0;
        while (!spi_dint && t < 5000) begin @(negedge clk); t++; end
        chk("dint_rise", {31'h0, spi_dint}, 32'h1);
        chk("dint_pulses", pulses, 24);
        wait_idle(5000);
        rd(8'h18, q); chk("rx_status", q, 32'h2);
        rd(8'h10, q); chk("rx_data", q, 32'hd3);
        chk("dint_clr", {31'h0, spi_dint}, 32'h0);

        // status polling, second read held for extra cycles
        clear_dev();
        resp_q = '{8'haa, 8'h03};
        wr(8'h10, 32'h105);
        wr(8'h10, 32'h600);
        wait_idle(5000);
        rd(8'h10, q); chk("poll1", q, 32'h3);
        clear_dev();
        resp_q = '{8'haa, 8'h00};
        wr(8'h10, 32'h105);
        wr(8'h10, 32'h600);
        wait_idle(5000);
        @(negedge clk);
        bus.wb_addr = 32'h10; bus.wb_we = 1'b0;
        bus.wb_stb = 1'b1; bus.wb_cyc = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.wb_ack && t < 20);
        chk("poll2", bus.wb_din, 32'h0);
        acks = 0;
        repeat (5) begin @(negedge clk); acks += int'(bus.wb_ack); end
        chk("held_ack", acks, 0);
        bus.wb_stb = 1'b0; bus.wb_cyc = 1'b0;
        rx_exp = 8'h00;

        // randomized frames against the byte-stream model
        for (int f = 0; f < 8; f++) begin
            wr(8'h20, {30'h0, 2'($urandom_range(0, 3))});
            rd(8'h10, q); chk("rnd_rx_pre", q, {24'h0, rx_exp});
            clear_dev();
            exp.delete();
            dint_exp = 1'b0;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                r = 8'($urandom);
                rcv = 1'($urandom);
                exp.push_back(b);
                resp_q.push_back(r);
                if (rcv) begin rx_exp = r; dint_exp = 1'b1; end
                wr(8'h10, {21'h0, rcv, i == n - 1, i == 0, b});
            end
            wait_idle(5000);
            check_frame("rnd", exp, 8 * n);
            rd(8'h18, q); chk("rnd_status", q, {30'h0, dint_exp, 1'b0});
            rd(8'h10, q); chk("rnd_rx", q, {24'h0, rx_exp});
        end

        // fill the FIFO; one extra write must wait for a pop
        wr(8'h20, 32'h3);
        clear_dev();
        exp.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            exp.push_back(b);
            wr(8'h10, {22'h0, i == 0, b});
        end
        rd(8'h18, q); chk("full_bit", {31'h0, q[2]}, 32'h1);
        b = 8'($urandom);
        exp.push_back(b);
        wb_xfer(8'h10, 1'b1, {22'h2, b}, q, c);
        chk("full_stall", {31'h0, c > 10}, 32'h1);
        wait_idle(20000);
        check_frame("full", exp, 144);

        // reset in the middle of a slow transfer with a stalled write
        wr(8'h20, 32'hffff);
        clear_dev();
        wr(8'h10, 32'h1aa);
        repeat (300) @(negedge clk);
        chk("mid_ss", {31'h0, spi_ss}, 32'h0);
        for (int i = 0; i < 16; i++) wr(8'h10, 32'h0aa);
        rd(8'h18, q); chk("mid_status", q, 32'h5);
        @(negedge clk);
        bus.wb_addr = 32'h10; bus.wb_we = 1'b1; bus.wb_dout = 32'h0aa;
        bus.wb_stb = 1'b1; bus.wb_cyc = 1'b1;
        acks = 0;
        repeat (50) begin @(negedge clk); acks += int'(bus.wb_ack); end
        chk("stall_ack", acks, 0);
        bus.wb_stb = 1'b0; bus.wb_cyc = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst1");
        #197 rst = 1'b0;
        rd(8'h18, q); chk("rst1_status", q, 32'h0);
        rd(8'h20, q); chk("rst1_div", q, 32'h00ff);
        rd(8'h10, q); chk("rst1_rx", q, 32'h0);

        // flushed FIFO: only the new byte goes out
        wr(8'h20, 32'h0);
        clear_dev();
        wr(8'h10, 32'h355);
        wait_idle(2000);
        exp = '{8'h55};
        check_frame("post_rst", exp, 8);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
